mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: IF -> ID -> EXE -> MEM -> WB (plus EXC).
// Build option: define OVF_TRAP_EN to send addi overflow in WB to the EXC state.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [2:0] alu_ctr,
  output logic       addi_sel,
  output logic       alu_src,
  output logic       ext_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] npc_sel,
  output logic [2:0] state,
  output logic       exc
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    K_NONE, K_ALU, K_ADDI, K_LW, K_SW, K_BEQ, K_J
  } kind_e;

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [2:0] alu_ctr_q, dec_alu;
  logic       alu_src_q, dec_src;
  logic       ext_op_q, dec_ext;
  logic       reg_dst_q, dec_dst;
  logic       mem_to_reg_q, dec_m2r;
  logic       addi_sel_q;

  // Instruction decode; only sampled in ID, while the IR is stable.
  always_comb begin
    kind_d  = K_NONE;
    dec_alu = 3'b000;
    dec_src = 1'b1;
    dec_ext = 1'b1;
    dec_dst = 1'b0;
    dec_m2r = 1'b0;
    case (op)
      6'b000000: begin
        dec_src = 1'b0;
        dec_ext = 1'b0;
        dec_dst = 1'b1;
        case (funct)
          6'b100001: begin kind_d = K_ALU; dec_alu = 3'b001; end
          6'b100011: begin kind_d = K_ALU; dec_alu = 3'b010; end
          6'b101010: begin kind_d = K_ALU; dec_alu = 3'b011; end
          default:   kind_d = K_NONE;
        endcase
      end
      6'b001101: begin kind_d = K_ALU;  dec_alu = 3'b100; dec_ext = 1'b0; end
      6'b001111: begin kind_d = K_ALU;  dec_alu = 3'b000; dec_ext = 1'b0; end
      6'b001000: begin kind_d = K_ADDI; dec_alu = 3'b001; end
      6'b001001: begin kind_d = K_ALU;  dec_alu = 3'b001; end
      6'b100011: begin kind_d = K_LW;   dec_alu = 3'b001; dec_m2r = 1'b1; end
      6'b101011: begin kind_d = K_SW;   dec_alu = 3'b001; end
      6'b000100: begin kind_d = K_BEQ;  dec_alu = 3'b010; dec_src = 1'b0; end
      6'b000010: kind_d = K_J;
      default:   kind_d = K_NONE;
    endcase
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (kind_d == K_NONE || kind_d == K_J) ? S_IF : S_EXE;
      S_EXE: begin
        case (kind_q)
          K_LW, K_SW: state_d = S_MEM;
          K_BEQ:      state_d = S_IF;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: state_d = (kind_q == K_LW) ? S_WB : S_IF;
`ifdef OVF_TRAP_EN
      S_WB:  state_d = (kind_q == K_ADDI && overflow) ? S_EXC : S_IF;
`else
      S_WB:  state_d = S_IF;
`endif
      default: state_d = S_IF;
    endcase
  end

  // Datapath selects are latched on ID->EXE and held until the instruction retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IF;
      kind_q       <= K_NONE;
      alu_ctr_q    <= 3'b000;
      alu_src_q    <= 1'b0;
      ext_op_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      addi_sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID && state_d == S_EXE) begin
        kind_q       <= kind_d;
        alu_ctr_q    <= dec_alu;
        alu_src_q    <= dec_src;
        ext_op_q     <= dec_ext;
        reg_dst_q    <= dec_dst;
        mem_to_reg_q <= dec_m2r;
        addi_sel_q   <= (kind_d == K_ADDI);
      end else if (state_d == S_IF || state_d == S_EXC) begin
        kind_q       <= K_NONE;
        alu_ctr_q    <= 3'b000;
        alu_src_q    <= 1'b0;
        ext_op_q     <= 1'b0;
        reg_dst_q    <= 1'b0;
        mem_to_reg_q <= 1'b0;
        addi_sel_q   <= 1'b0;
      end
    end
  end

`ifdef OVF_TRAP_EN
  logic exc_q;
  always_ff @(posedge clk) begin
    if (reset) exc_q <= 1'b0;
    else       exc_q <= (state_d == S_EXC);
  end
  assign exc = exc_q;
`else
  assign exc = 1'b0;
`endif

  // Write enables follow the current state and the same-cycle ALU flags,
  // and are forced low while reset is held so an aborted instruction never commits.
  assign ir_wr  = !reset && (state_q == S_IF);
  assign pc_wr  = !reset && ((state_q == S_IF) ||
                             (state_q == S_ID && kind_d == K_J) ||
                             (state_q == S_EXE && kind_q == K_BEQ && zero));
  assign mem_wr = !reset && (state_q == S_MEM) && (kind_q == K_SW);
  assign reg_wr = !reset && (state_q == S_WB) && !(kind_q == K_ADDI && overflow);

  always_comb begin
    npc_sel = 2'b00;
    if (state_q == S_ID && kind_d == K_J)                   npc_sel = 2'b10;
    else if (state_q == S_EXE && kind_q == K_BEQ && zero)   npc_sel = 2'b01;
  end

  assign alu_ctr    = alu_ctr_q;
  assign alu_src    = alu_src_q;
  assign ext_op     = ext_op_q;
  assign reg_dst    = reg_dst_q;
  assign mem_to_reg = mem_to_reg_q;
  assign addi_sel   = addi_sel_q;
  assign state      = state_q;

endmodule
